shift_rx_deser: RTL and testbench
=================================

Name: shift_rx_deser

Overview:
- Serial-to-parallel receiver: the far end of the team's right-shift serializer, which emits q[0] first and shifts right.
- Collects WIDTH serial bits LSB-first, qualified by a per-bit strobe, into a parallel word.
- Presents the word on a valid/ready output handshake.
- Sits between a serial link and a parallel consumer, e.g. a register file or FIFO.

Parameters:
- WIDTH, 4, word length in bits (≥2).
- CNT_W, $clog2(WIDTH), bit counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- clr_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- sync  input  1  synchronous frame realign: discards the partial word.
- dout  output  WIDTH  received parallel word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- bit_cnt  output  CNT_W  bits collected in the current word.

Behaviour:
- Reset (clr_n=0, async): shreg=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, state=SHIFT. Reset mid-word discards the partial word.
- Shift rule: on sin_valid, shreg <= {sin, shreg[WIDTH-1:1]}. The first-received bit ends in dout[0].
- Counter: bit_cnt increments on each sin_valid and wraps to 0 after the WIDTH-th bit. No wrap to any other value.
- Completion: sin_valid while bit_cnt==WIDTH-1. On the next edge dout <= {sin, shreg[WIDTH-1:1]} and dout_valid <= 1. Latency is 1 clk from the last bit's sampling edge to dout_valid.
- Back-to-back frames: collection continues while dout_valid=1, so words can arrive with no gap.
- Handshake: transfer occurs when dout_valid && dout_ready. dout_valid clears on the next edge unless a completion occurs the same cycle, in which case dout is loaded with the new word and dout_valid stays 1.
- dout is stable while dout_valid=1 and dout_ready=0.
- Overrun: completion while dout_valid=1 and dout_ready=0 keeps the old word, drops the new word, and asserts overrun for 1 clk. bit_cnt still wraps to 0.
- sync: forces bit_cnt=0 and state=SHIFT and ignores sin_valid that cycle. dout, dout_valid and the handshake are unaffected. sync takes priority over sin_valid.
- sin is ignored when sin_valid=0.
- FSM states: SHIFT (collecting data bits) and PAR (feature only, see below). Without the feature the FSM stays in SHIFT.

Optional Feature:
- Macro SHIFT_RX_PARITY_EN.
- Defined:
  - After WIDTH data bits, the FSM enters PAR and waits for one more sin_valid bit, the even-parity bit.
  - Completion, and all completion rules above, occur on that bit instead of the WIDTH-th data bit.
  - New output parity_err (1 bit) is registered with dout: 1 when ^{word, parity_bit} != 0. It resets to 0 and is held with dout.
  - sync in PAR returns the FSM to SHIFT.
- Undefined: no PAR state and no parity_err port; behaviour as above.

Decomposition:
- Shared package shift_pkg:
  - FSM state typedef (ST_SHIFT, ST_PAR).
  - Default width constant SHIFT_W=4, shared with the serializer.
  - Parity polarity constant PAR_EVEN=1.
- One natural sub-module: shift_rx_core, the counter, shift register and FSM, producing a completion strobe plus the word.
- The top level adds the output holding register, handshake and overrun logic.

Test Plan:
- Reset: assert clr_n=0 mid-word, after 2 bits → all outputs 0 immediately. Then send bits 1,0,1,1 → dout=4'b1101, dout_valid=1 exactly 1 clk after the 4th bit.
- Gapped strobes: bits 0,1,1,0 with sin_valid idle cycles between them, and sin toggling during the idle cycles → dout=4'b0110; idle-cycle sin is ignored.
- Back-to-back with dout_ready=1: send words 4'b1010 then 4'b0101 continuously → two transfers, dout_valid never drops between them; on the shared cycle dout switches to 4'b0101.
- Overrun: hold dout_ready=0 and send 2 words (0011, then 1100) → dout stays 0011, overrun pulses 1 clk on the second completion, bit_cnt=0 afterwards.
- sync: after 2 bits assert sync together with sin_valid, then send 1,1,1,0 → dout=4'b0111, bit_cnt=0 after sync, no spurious completion.
- Parity (SHIFT_RX_PARITY_EN defined): send 1,0,1,1 then parity bit 1 → parity_err=0. Repeat with parity bit 0 → parity_err=1 and dout=4'b1101 in both cases.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the right-shift serial link (serializer and shift_rx_deser).
// Holds the receive FSM state type, the default word width and the parity polarity.
package shift_pkg;

  typedef enum logic {
    ST_SHIFT = 1'b0,
    ST_PAR   = 1'b1
  } rx_state_t;

  localparam int SHIFT_W = 4;

  // 1: even parity (data plus parity bit carry an even number of ones).
  localparam bit PAR_EVEN = 1'b1;

  // Error flag from the XOR of all received bits, data and parity together.
  function automatic logic parity_flag(input logic odd_ones);
    return odd_ones ^ (PAR_EVEN ? 1'b0 : 1'b1);
  endfunction

endpackage

// File: rtl/shift_rx_core.sv
// Bit collector for shift_rx_deser: bit counter, right-shift register and framing FSM.
// Defining SHIFT_RX_PARITY_EN adds a trailing parity bit to every frame (PAR state).
module shift_rx_core
  import shift_pkg::*;
#(
  parameter  int WIDTH = SHIFT_W,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_sin,
  input  logic             i_sin_valid,
  input  logic             i_sync,
  output logic             o_done,
  output logic [WIDTH-1:0] o_word,
`ifdef SHIFT_RX_PARITY_EN
  output logic             o_par_err,
`endif
  output logic [CNT_W-1:0] o_bit_cnt
);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_take;
  logic             w_last;
  logic             w_shift_en;
  logic [WIDTH-1:0] w_shifted;

  // sync wins over a coincident strobe: that bit is dropped with the partial word.
  assign w_take    = i_sin_valid && !i_sync;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_shifted = {i_sin, r_shreg[WIDTH-1:1]};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    w_state_nxt = r_state;
    w_shift_en  = 1'b0;
    o_done      = 1'b0;
    unique case (r_state)
      ST_SHIFT: begin
        if (w_take) begin
          w_shift_en = 1'b1;
          if (w_last) begin
`ifdef SHIFT_RX_PARITY_EN
            w_state_nxt = ST_PAR;
`else
            o_done = 1'b1;
`endif
          end
        end
      end
      ST_PAR: begin
        if (w_take) begin
          o_done      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
    endcase
    if (i_sync) w_state_nxt = ST_SHIFT;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= ST_SHIFT;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      if (i_sync) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
      end
      if (w_shift_en) r_shreg <= w_shifted;
    end
  end

`ifdef SHIFT_RX_PARITY_EN
  // In PAR the data word is already complete in r_shreg; i_sin is the parity bit.
  assign o_word    = r_shreg;
  assign o_par_err = parity_flag(^{r_shreg, i_sin});
`else
  // The word is taken straight from the shifter input, so r_shreg[0] never reaches dout.
  logic w_unused;
  assign o_word   = w_shifted;
  assign w_unused = r_shreg[0];
`endif

  assign o_bit_cnt = r_cnt;

endmodule

// File: rtl/shift_rx_deser.sv
// Serial-to-parallel receiver, LSB first, with a valid/ready output and overrun pulse.
// Optional even-parity frame bit and parity_err output via SHIFT_RX_PARITY_EN.
module shift_rx_deser
  import shift_pkg::*;
#(
  parameter  int WIDTH = SHIFT_W,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
`ifdef SHIFT_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic [CNT_W-1:0] bit_cnt
);

  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

`ifdef SHIFT_RX_PARITY_EN
  logic w_par_err;
  logic r_par_err;
`endif

  shift_rx_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk         (clk),
    .clr_n       (clr_n),
    .i_sin       (sin),
    .i_sin_valid (sin_valid),
    .i_sync      (sync),
    .o_done      (w_done),
    .o_word      (w_word),
`ifdef SHIFT_RX_PARITY_EN
    .o_par_err   (w_par_err),
`endif
    .o_bit_cnt   (bit_cnt)
  );

  assign w_xfer   = r_dout_valid && dout_ready;
  // A new word may land if the holding register is empty or being drained this cycle.
  assign w_accept = w_done && (!r_dout_valid || dout_ready);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef SHIFT_RX_PARITY_EN
      r_par_err    <= 1'b0;
`endif
    end else begin
      r_overrun <= w_done && !w_accept;
      if (w_accept) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
`ifdef SHIFT_RX_PARITY_EN
        r_par_err    <= w_par_err;
`endif
      end else if (w_xfer) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
`ifdef SHIFT_RX_PARITY_EN
  assign parity_err = r_par_err;
`endif

endmodule

// File: tb/tb_shift_rx_deser.sv
// Self-checking bench for shift_rx_deser: directed cases with literal expectations,
// then randomized traffic compared every cycle against a frame-level queue model.
module tb_shift_rx_deser;
  import shift_pkg::*;

  localparam int WIDTH = SHIFT_W;
  localparam int CNT_W = $clog2(WIDTH);
`ifdef SHIFT_RX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk;
  logic             clr_n;
  logic             sin;
  logic             sin_valid;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic [CNT_W-1:0] bit_cnt;
`ifdef SHIFT_RX_PARITY_EN
  logic             parity_err;
`endif

  shift_rx_deser #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
`ifdef SHIFT_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .bit_cnt    (bit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic cmp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits of the current frame kept in a queue; a frame is
  // complete when the queue holds FRAME bits, bit i of the word being the i-th received.
  logic             m_bits[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid;
  logic             m_ovr;
  logic             m_perr;

  always @(posedge clk or negedge clr_n) begin : model
    logic             done;
    logic [WIDTH-1:0] nw;
    if (!clr_n) begin
      m_bits.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
    end else begin
      done = 1'b0;
      nw   = '0;
      if (sync) begin
        m_bits.delete();
      end else if (sin_valid) begin
        m_bits.push_back(sin);
        if (m_bits.size() == FRAME) begin
          done = 1'b1;
          for (int i = 0; i < WIDTH; i++) nw[i] = m_bits[i];
          m_ovr = m_valid && !dout_ready;
          if (!m_ovr) begin
`ifdef SHIFT_RX_PARITY_EN
            m_perr = (^nw) ^ m_bits[WIDTH];
`endif
            m_dout  = nw;
            m_valid = 1'b1;
          end
          m_bits.delete();
        end
      end
      if (!done) begin
        m_ovr = 1'b0;
        if (m_valid && dout_ready) m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && clr_n) begin
      check("dout",       32'(dout),       32'(m_dout));
      check("dout_valid", 32'(dout_valid), 32'(m_valid));
      check("overrun",    32'(overrun),    32'(m_ovr));
      check("bit_cnt",    32'(bit_cnt),    32'(m_bits.size() % WIDTH));
`ifdef SHIFT_RX_PARITY_EN
      check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    end
  end

  task automatic step(input logic v, input logic b, input logic s, input logic r);
    sin_valid  = v;
    sin        = b;
    sync       = s;
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic frame_bit(input logic [WIDTH-1:0] w, input int i);
    logic [WIDTH-1:0] tmp;
    tmp = w;
    if (i < WIDTH) return tmp[i];
    return ^tmp;
  endfunction

  // Sends one full frame; vld_before is dout_valid just before the last bit's edge.
  task automatic send_word(input logic [WIDTH-1:0] w, input logic r_body, input logic r_last,
                           output logic vld_before);
    vld_before = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (i == FRAME - 1) begin
        vld_before = dout_valid;
        step(1'b1, frame_bit(w, i), 1'b0, r_last);
      end else begin
        step(1'b1, frame_bit(w, i), 1'b0, r_body);
      end
    end
  endtask

  logic             vb;
  logic [WIDTH-1:0] g;

  initial begin
    clr_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; sync = 1'b0; dout_ready = 1'b0;
    cmp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dout",    32'(dout),       32'h0);
    check("rst_valid",   32'(dout_valid), 32'h0);
    check("rst_overrun", 32'(overrun),    32'h0);
    check("rst_bit_cnt", 32'(bit_cnt),    32'h0);
    clr_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset in the middle of a word, then a clean word.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_cnt_pre_rst", 32'(bit_cnt), 32'd2);
    #2 clr_n = 1'b0;
    #1;
    check("t1_rst_dout",  32'(dout),       32'h0);
    check("t1_rst_valid", 32'(dout_valid), 32'h0);
    check("t1_rst_ovr",   32'(overrun),    32'h0);
    check("t1_rst_cnt",   32'(bit_cnt),    32'h0);
    clr_n = 1'b1;
    send_word(4'b1101, 1'b0, 1'b0, vb);
    check("t1_valid_before", 32'(vb),         32'h0);
    check("t1_dout",         32'(dout),       32'b1101);
    check("t1_valid",        32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_drained", 32'(dout_valid), 32'h0);

    // Gapped strobes with sin toggling on idle cycles.
    g = 4'b0110;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, frame_bit(g, i), 1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    check("t2_dout",  32'(dout),       32'b0110);
    check("t2_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back: second completion coincides with the transfer of the first word.
    send_word(4'b1010, 1'b0, 1'b0, vb);
    check("t3_dout_a", 32'(dout), 32'b1010);
    send_word(4'b0101, 1'b0, 1'b1, vb);
    check("t3_valid_held", 32'(vb),         32'h1);
    check("t3_dout_b",     32'(dout),       32'b0101);
    check("t3_valid_b",    32'(dout_valid), 32'h1);
    check("t3_no_ovr",     32'(overrun),    32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: consumer stalled across two completions.
    send_word(4'b0011, 1'b0, 1'b0, vb);
    send_word(4'b1100, 1'b0, 1'b0, vb);
    check("t4_dout",  32'(dout),       32'b0011);
    check("t4_valid", 32'(dout_valid), 32'h1);
    check("t4_ovr",   32'(overrun),    32'h1);
    check("t4_cnt",   32'(bit_cnt),    32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_ovr_pulse", 32'(overrun), 32'h0);
    check("t4_dout_held", 32'(dout),    32'b0011);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_drained", 32'(dout_valid), 32'h0);

    // sync discards a partial word, including a coincident strobe.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t5_cnt",   32'(bit_cnt),    32'h0);
    check("t5_valid", 32'(dout_valid), 32'h0);
    send_word(4'b0111, 1'b0, 1'b0, vb);
    check("t5_valid_before", 32'(vb),   32'h0);
    check("t5_dout",         32'(dout), 32'b0111);
    step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SHIFT_RX_PARITY_EN
    // Parity: correct and wrong parity bit on the same data word.
    for (int i = 0; i < WIDTH; i++) step(1'b1, frame_bit(4'b1101, i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_perr_ok",  32'(parity_err), 32'h0);
    check("t6_dout_ok",  32'(dout),       32'b1101);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH; i++) step(1'b1, frame_bit(4'b1101, i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_perr_bad", 32'(parity_err), 32'h1);
    check("t6_dout_bad", 32'(dout),       32'b1101);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic, occasional sync and asynchronous reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        clr_n = 1'b0;
        #2;
        clr_n = 1'b1;
      end
      step($urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
           $urandom_range(0, 31) == 0, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
